io_port_bridge: RTL and testbench

Multi-channel I/O bridge between the processor's single IO strobe interface (IO_port_ID / IO_write_data / IO_read_data / strobes) and up to NUM_PORTS byte-stream peripherals such as UARTs. Each channel has a TX FIFO filled by processor port writes and an RX FIFO drained by processor port reads. Each channel also exposes a status/control register and a maskable interrupt. It sits beside processor_top and generalises the single unbuffered IO port into parametrised, buffered, multi-channel I/O.

---
 rtl/io_port_bridge.sv | 160 ++++++++++++++++
 tb/tb_io_port_bridge.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// Buffered multi-channel bridge from the processor IO strobe bus to
// per-channel byte-stream peripherals, with TX/RX FIFOs, status and irq.
module io_port_bridge #(
    parameter int         NUM_PORTS  = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] PORT_BASE  = 8'h00
) (
    input  logic                   clk100,
    input  logic                   reset,
    input  logic [7:0]             IO_port_ID,
    input  logic [7:0]             IO_write_data,
    input  logic                   IO_write_strobe,
    input  logic                   IO_read_strobe,
    output logic [7:0]             IO_read_data,
    output logic [8*NUM_PORTS-1:0] tx_data,
    output logic [NUM_PORTS-1:0]   tx_valid,
    input  logic [NUM_PORTS-1:0]   tx_ready,
    input  logic [8*NUM_PORTS-1:0] rx_data,
    input  logic [NUM_PORTS-1:0]   rx_valid,
    output logic [NUM_PORTS-1:0]   rx_ready,
    output logic                   irq
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [7:0]    tx_mem [NUM_PORTS][FIFO_DEPTH];
    logic [7:0]    rx_mem [NUM_PORTS][FIFO_DEPTH];

    logic [PW-1:0] tx_wp_q [NUM_PORTS];
    logic [PW-1:0] tx_wp_d [NUM_PORTS];
    logic [PW-1:0] tx_rp_q [NUM_PORTS];
    logic [PW-1:0] tx_rp_d [NUM_PORTS];
    logic [PW-1:0] rx_wp_q [NUM_PORTS];
    logic [PW-1:0] rx_wp_d [NUM_PORTS];
    logic [PW-1:0] rx_rp_q [NUM_PORTS];
    logic [PW-1:0] rx_rp_d [NUM_PORTS];
    logic [CW-1:0] tx_cnt_q [NUM_PORTS];
    logic [CW-1:0] tx_cnt_d [NUM_PORTS];
    logic [CW-1:0] rx_cnt_q [NUM_PORTS];
    logic [CW-1:0] rx_cnt_d [NUM_PORTS];

    logic [NUM_PORTS-1:0] tx_ovf_q, tx_ovf_d;
    logic [NUM_PORTS-1:0] rx_unf_q, rx_unf_d;
    logic [NUM_PORTS-1:0] irq_en_q, irq_en_d;
    logic                 irq_q, irq_d;

    logic [NUM_PORTS-1:0] hit, wr_dat, wr_stat, rd_dat;
    logic [NUM_PORTS-1:0] tx_ne, tx_full, rx_ne, rx_full;
    logic [NUM_PORTS-1:0] tx_push, tx_pop, rx_push, rx_pop;

    logic [8:0] off;
    logic [7:0] sel;
    logic       mapped;
    logic       is_stat;
    logic [7:0] rd_mux;

    // Nine-bit subtract so IDs below PORT_BASE show up as a borrow
    assign off     = {1'b0, IO_port_ID} - {1'b0, PORT_BASE};
    assign mapped  = !off[8] && (off[7:0] < 8'(2 * NUM_PORTS));
    assign is_stat = off[0];
    assign sel     = {1'b0, off[7:1]};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
        assign hit[g]     = mapped && (sel == 8'(g));
        assign tx_ne[g]   = tx_cnt_q[g] != '0;
        assign tx_full[g] = tx_cnt_q[g] == FULL;
        assign rx_ne[g]   = rx_cnt_q[g] != '0;
        assign rx_full[g] = rx_cnt_q[g] == FULL;
    end

    assign wr_dat  = {NUM_PORTS{IO_write_strobe & ~is_stat}} & hit;
    assign wr_stat = {NUM_PORTS{IO_write_strobe & is_stat}} & hit;
    assign rd_dat  = {NUM_PORTS{IO_read_strobe & ~is_stat}} & hit;
    assign tx_push = wr_dat & ~tx_full;
    assign tx_pop  = tx_ne & tx_ready;
    assign rx_push = rx_valid & ~rx_full;
    assign rx_pop  = rd_dat & rx_ne;

    assign tx_valid = tx_ne;
    assign rx_ready = ~rx_full;
    assign irq      = irq_q;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        irq_en_d = irq_en_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (tx_push[i]) tx_wp_d[i] = tx_wp_q[i] + PW'(1);
            if (tx_pop[i])  tx_rp_d[i] = tx_rp_q[i] + PW'(1);
            if (rx_push[i]) rx_wp_d[i] = rx_wp_q[i] + PW'(1);
            if (rx_pop[i])  rx_rp_d[i] = rx_rp_q[i] + PW'(1);
            tx_cnt_d[i] = tx_cnt_q[i] + CW'(tx_push[i]) - CW'(tx_pop[i]);
            rx_cnt_d[i] = rx_cnt_q[i] + CW'(rx_push[i]) - CW'(rx_pop[i]);
            // A new event outranks a same-cycle clear
            tx_ovf_d[i] = (wr_dat[i] & tx_full[i])
                        | (tx_ovf_q[i] & ~(wr_stat[i] & IO_write_data[3]));
            rx_unf_d[i] = (rd_dat[i] & ~rx_ne[i])
                        | (rx_unf_q[i] & ~(wr_stat[i] & IO_write_data[4]));
            if (wr_stat[i]) irq_en_d[i] = IO_write_data[5];
        end
        irq_d = |(irq_en_q & (rx_ne | tx_ovf_q | rx_unf_q));
    end

    always_comb begin
        rd_mux  = 8'h00;
        tx_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (tx_ne[i]) tx_data[8*i +: 8] = tx_mem[i][tx_rp_q[i]];
            if (hit[i]) begin
                if (is_stat)
                    rd_mux = {2'b00, irq_en_q[i], rx_unf_q[i], tx_ovf_q[i],
                              ~tx_ne[i], tx_full[i], rx_ne[i]};
                else if (rx_ne[i])
                    rd_mux = rx_mem[i][rx_rp_q[i]];
            end
        end
        IO_read_data = (IO_read_strobe && reset) ? rd_mux : 8'h00;
    end

    always_ff @(posedge clk100) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (tx_push[i]) tx_mem[i][tx_wp_q[i]] <= IO_write_data;
            if (rx_push[i]) rx_mem[i][rx_wp_q[i]] <= rx_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            tx_wp_q  <= '{default: '0};
            tx_rp_q  <= '{default: '0};
            rx_wp_q  <= '{default: '0};
            rx_rp_q  <= '{default: '0};
            tx_cnt_q <= '{default: '0};
            rx_cnt_q <= '{default: '0};
            tx_ovf_q <= '0;
            rx_unf_q <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            tx_ovf_q <= tx_ovf_d;
            rx_unf_q <= rx_unf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Scoreboard bench for io_port_bridge: queue-based reference model feeds
// expected reads and TX bytes; a negedge monitor compares DUT outputs.
module tb_io_port_bridge;
    localparam int N = 4;
    localparam int D = 8;
    localparam int BASE = 0;

    logic         clk100 = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   io_id = 8'h00;
    logic [7:0]   io_wd = 8'h00;
    logic         io_ws = 1'b0;
    logic         io_rs = 1'b0;
    logic [7:0]   io_rd_data;
    logic [8*N-1:0] tx_data;
    logic [N-1:0] tx_valid;
    logic [N-1:0] tx_ready = '0;
    logic [8*N-1:0] rx_data = '0;
    logic [N-1:0] rx_valid = '0;
    logic [N-1:0] rx_ready;
    logic         irq;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] tx_m [N][$];
    logic [7:0] rx_m [N][$];
    bit         ovf_m [N];
    bit         unf_m [N];
    bit         en_m [N];
    bit         irq_m;
    // Scoreboard queues
    logic [7:0] exp_tx [N][$];
    logic [7:0] rd_q [$];

    io_port_bridge #(.NUM_PORTS(N), .FIFO_DEPTH(D), .PORT_BASE(8'(BASE))) dut (
        .clk100(clk100), .reset(reset),
        .IO_port_ID(io_id), .IO_write_data(io_wd),
        .IO_write_strobe(io_ws), .IO_read_strobe(io_rs),
        .IO_read_data(io_rd_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] stat_m(input int c);
        return {2'b00, en_m[c], unf_m[c], ovf_m[c], tx_m[c].size() == 0,
                tx_m[c].size() == D, rx_m[c].size() != 0};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            tx_m[c].delete();
            rx_m[c].delete();
            exp_tx[c].delete();
            ovf_m[c] = 0;
            unf_m[c] = 0;
            en_m[c] = 0;
        end
        rd_q.delete();
        irq_m = 0;
    endtask

    // One clock: predict from pre-edge state, then apply at the edge.
    task automatic step(input bit lit_en = 0, input logic [7:0] lit = 8'h00);
        int off;
        bit mapped;
        bit isst;
        int ch;
        bit irq_n;
        logic [7:0] e;
        bit txpu [N], txpo [N], rxpu [N], rxpo [N], ovs [N], uns [N], ws [N];
        off = int'(io_id) - BASE;
        mapped = off >= 0 && off < 2 * N;
        ch = mapped ? off / 2 : -1;
        isst = mapped && (off % 2 == 1);
        irq_n = 0;
        for (int c = 0; c < N; c++)
            if (en_m[c] && (rx_m[c].size() != 0 || ovf_m[c] || unf_m[c]))
                irq_n = 1;
        if (io_rs) begin
            e = 8'h00;
            if (mapped && isst) e = stat_m(ch);
            else if (mapped && rx_m[ch].size() != 0) e = rx_m[ch][0];
            rd_q.push_back(lit_en ? lit : e);
        end
        for (int c = 0; c < N; c++) begin
            bit wd, rd;
            wd = io_ws && !isst && ch == c;
            rd = io_rs && !isst && ch == c;
            ws[c] = io_ws && isst && ch == c;
            txpu[c] = wd && tx_m[c].size() < D;
            ovs[c] = wd && tx_m[c].size() == D;
            txpo[c] = tx_m[c].size() > 0 && tx_ready[c];
            rxpo[c] = rd && rx_m[c].size() > 0;
            uns[c] = rd && rx_m[c].size() == 0;
            rxpu[c] = rx_valid[c] && rx_m[c].size() < D;
        end
        @(posedge clk100);
        for (int c = 0; c < N; c++) begin
            ovf_m[c] = ovs[c] || (ovf_m[c] && !(ws[c] && io_wd[3]));
            unf_m[c] = uns[c] || (unf_m[c] && !(ws[c] && io_wd[4]));
            if (ws[c]) en_m[c] = io_wd[5];
            if (txpo[c]) void'(tx_m[c].pop_front());
            if (txpu[c]) begin
                tx_m[c].push_back(io_wd);
                exp_tx[c].push_back(io_wd);
            end
            if (rxpo[c]) void'(rx_m[c].pop_front());
            if (rxpu[c]) rx_m[c].push_back(rx_data[8*c +: 8]);
        end
        irq_m = irq_n;
        #1;
    endtask

    task automatic io_wr(input logic [7:0] id, input logic [7:0] d);
        io_id = id;
        io_wd = d;
        io_ws = 1;
        step();
        io_ws = 0;
    endtask

    task automatic io_rd(input logic [7:0] id, input bit le = 0,
                         input logic [7:0] lit = 8'h00);
        io_id = id;
        io_rs = 1;
        step(le, lit);
        io_rs = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic rx_push(input int c, input logic [7:0] d);
        rx_valid[c] = 1;
        rx_data[8*c +: 8] = d;
        step();
        rx_valid[c] = 0;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    always @(negedge clk100) begin
        if (reset) begin
            if (io_rs) begin
                if (rd_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL rd_q: read with no expectation at %0t", $time);
                end else begin
                    chk("io_read", {24'h0, io_rd_data}, {24'h0, rd_q.pop_front()});
                end
            end
            for (int c = 0; c < N; c++) begin
                chk("tx_valid", {31'h0, tx_valid[c]}, {31'h0, tx_m[c].size() != 0});
                chk("rx_ready", {31'h0, rx_ready[c]}, {31'h0, rx_m[c].size() < D});
                if (tx_valid[c]) begin
                    if (exp_tx[c].size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL tx_data: lane %0d unexpected %h", c, tx_data[8*c +: 8]);
                    end else begin
                        chk("tx_data", {24'h0, tx_data[8*c +: 8]}, {24'h0, exp_tx[c][0]});
                        if (tx_ready[c]) void'(exp_tx[c].pop_front());
                    end
                end
            end
            chk("irq", {31'h0, irq}, {31'h0, irq_m});
        end
    end

    initial begin
        model_reset();
        #12;
        chk("rst_tx_valid", {28'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {28'h0, rx_ready}, 32'hF);
        chk("rst_tx_data", tx_data, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_io_read", {24'h0, io_rd_data}, 32'h0);
        @(posedge clk100);
        #1 reset = 1;

        // TX latency and drain order
        io_wr(8'h00, 8'hA5);
        chk("tx0_valid", {31'h0, tx_valid[0]}, 32'h1);
        chk("tx0_head", {24'h0, tx_data[7:0]}, 32'hA5);
        io_wr(8'h00, 8'h3C);
        tx_ready[0] = 1;
        idle(3);
        chk("tx0_drained", {31'h0, tx_valid[0]}, 32'h0);
        tx_ready[0] = 0;

        // TX overflow on channel 1
        for (int k = 1; k <= 9; k++) io_wr(8'h02, 8'(k));
        io_rd(8'h03, 1, 8'h0A);
        tx_ready[1] = 1;
        idle(10);
        tx_ready[1] = 0;
        io_wr(8'h03, 8'h08);
        io_rd(8'h03, 1, 8'h04);

        // RX reads and underflow on channel 2
        rx_push(2, 8'h11);
        rx_push(2, 8'h22);
        io_rd(8'h04, 1, 8'h11);
        io_rd(8'h04, 1, 8'h22);
        io_rd(8'h04, 1, 8'h00);
        io_rd(8'h05, 1, 8'h14);
        io_wr(8'h05, 8'h10);

        // irq on channel 3
        io_wr(8'h07, 8'h20);
        rx_push(3, 8'h5A);
        idle(1);
        chk("irq_set", {31'h0, irq}, 32'h1);
        io_rd(8'h06, 1, 8'h5A);
        idle(1);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        io_wr(8'h07, 8'h00);

        // RX full, back-pressure and pointer wrap on channel 0
        for (int k = 0; k < D; k++) rx_push(0, 8'h30 + 8'(k));
        chk("rx0_full", {31'h0, rx_ready[0]}, 32'h0);
        rx_valid[0] = 1;
        rx_data[7:0] = 8'h40;
        io_rd(8'h00, 1, 8'h30);
        chk("rx0_ready_back", {31'h0, rx_ready[0]}, 32'h1);
        step();
        rx_valid[0] = 0;
        for (int k = 1; k < D; k++) io_rd(8'h00, 1, 8'h30 + 8'(k));
        io_rd(8'h00, 1, 8'h40);

        // Reset with data held in FIFOs
        io_wr(8'h00, 8'h77);
        io_wr(8'h02, 8'h88);
        rx_push(1, 8'h99);
        #2 reset = 0;
        io_id = 8'h01;
        io_rs = 1;
        #1;
        chk("mid_tx_valid", {28'h0, tx_valid}, 32'h0);
        chk("mid_rx_ready", {28'h0, rx_ready}, 32'hF);
        chk("mid_tx_data", tx_data, 32'h0);
        chk("mid_irq", {31'h0, irq}, 32'h0);
        chk("mid_io_read", {24'h0, io_rd_data}, 32'h0);
        io_rs = 0;
        model_reset();
        @(posedge clk100);
        @(posedge clk100);
        #1 reset = 1;
        for (int c = 0; c < N; c++) io_rd(8'(2 * c + 1), 1, 8'h04);

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            int op;
            tx_ready = N'($urandom);
            rx_valid = N'($urandom) & N'($urandom);
            rx_data = $urandom;
            op = $urandom_range(0, 9);
            io_id = 8'($urandom_range(0, 2 * N + 1));
            io_wd = 8'($urandom);
            io_ws = (op <= 2) || (op == 6);
            io_rs = (op >= 3 && op <= 6);
            step();
            io_ws = 0;
            io_rs = 0;
        end

        // Drain everything and confirm nothing is left outstanding
        tx_ready = '1;
        rx_valid = '0;
        idle(D + 4);
        for (int c = 0; c < N; c++)
            for (int k = 0; k < D; k++) io_rd(8'(2 * c));
        for (int c = 0; c < N; c++)
            chk("tx_leftover", exp_tx[c].size(), 32'h0);
        chk("rd_leftover", rd_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
